// File: rtl/flopenr_pipe_if.sv
// Handshake bundle for flopenr_pipe: upstream valid/ready/data, downstream valid/ready/data
// and the occupancy count. master is the environment side, slave is the pipe.
interface flopenr_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 2
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/flopenr_pipe.sv
// Elastic pipeline register: DEPTH valid-tagged stages with collapsing bubbles,
// global hold (freeze) and synchronous flush (invalidate, data kept).
module flopenr_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          hold,
  flopenr_pipe_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]               count_q, count_d;
  logic [DEPTH-1:0]            ld;
  logic                        chain;

  always_comb begin
    // Walk from the output back to the input so each stage sees its downstream load.
    chain = bus.out_ready;
    ld    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain = ~v_q[k] | chain;
      ld[k] = chain & ~hold;
    end

    v_d = v_q;
    d_d = d_q;
    if (ld[0]) begin
      v_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        d_d[0] = bus.in_data;
      end
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (ld[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          d_d[k] = d_q[k-1];
        end
      end
    end

    // Flush beats everything, including a beat accepted this same cycle.
    if (flush) begin
      v_d = '0;
    end

    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CW'(v_d[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q     <= '0;
      d_q     <= {DEPTH{RESET_VAL}};
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.count     = count_q;
endmodule

// File: tb/tb_flopenr_pipe.sv
// Directed self-checking bench for flopenr_pipe (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
module tb_flopenr_pipe;
  logic clk;
  logic reset;
  logic flush;
  logic hold;
  int   errors;
  int   checks;

  flopenr_pipe_if #(.WIDTH(8), .CW(2)) bus ();

  flopenr_pipe #(
    .WIDTH    (8),
    .DEPTH    (3),
    .RESET_VAL(8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .hold (hold),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 8'hA5) begin
      errors++; $display("FAIL reset_out_data got=%h want=a5", bus.out_data);
    end
    checks++;
    if (bus.count !== 2'd0) begin
      errors++; $display("FAIL reset_count got=%0d want=0", bus.count);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [7:0] exp_cnt [8];
    exp_cnt = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd1};
    bus.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      bus.in_valid = (cyc <= 6);
      bus.in_data  = 8'(cyc);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready cyc=%0d got=%b want=1", cyc, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== (cyc >= 3)) begin
        errors++; $display("FAIL stream_out_valid cyc=%0d got=%b want=%b", cyc, bus.out_valid,
                           (cyc >= 3));
      end
      if (cyc >= 3) begin
        checks++;
        if (bus.out_data !== 8'(cyc - 2)) begin
          errors++; $display("FAIL stream_out_data cyc=%0d got=%h want=%h", cyc, bus.out_data,
                             8'(cyc - 2));
        end
      end
      checks++;
      if (bus.count !== exp_cnt[cyc-1][1:0]) begin
        errors++; $display("FAIL stream_count cyc=%0d got=%0d want=%0d", cyc, bus.count,
                           exp_cnt[cyc-1]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin
      errors++; $display("FAIL stream_drain got=v%b/c%0d want=v0/c0", bus.out_valid, bus.count);
    end
    checks++;
    if (bus.out_data !== 8'h06) begin
      errors++; $display("FAIL empty_holds_data got=%h want=06", bus.out_data);
    end
  endtask

  task automatic test_full();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h10 + 8'(i);
      #1;
      checks++;
      if (bus.in_ready !== (i < 3)) begin
        errors++; $display("FAIL full_in_ready i=%0d got=%b want=%b", i, bus.in_ready, (i < 3));
      end
      if (i < 3) tick();
    end
    tick();
    tick();
    checks++;
    if (bus.count !== 2'd3 || bus.out_data !== 8'h10 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL full_stall got=c%0d/d%h/v%b want=c3/d10/v1", bus.count,
                         bus.out_data, bus.out_valid);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_data !== 8'h10 + 8'(i) || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL full_release i=%0d got=%h/v%b want=%h/v1", i, bus.out_data,
                           bus.out_valid, 8'h10 + 8'(i));
      end
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin
      errors++; $display("FAIL full_drain got=v%b/c%0d want=v0/c0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_bubble();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h20;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h21;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.count !== 2'd2 || bus.out_data !== 8'h20 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL bubble_collapse got=c%0d/d%h/v%b want=c2/d20/v1", bus.count,
                         bus.out_data, bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bubble_in_ready got=%b want=1", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_data !== 8'h21 || bus.out_valid !== 1'b1 || bus.count !== 2'd1) begin
      errors++; $display("FAIL bubble_order got=d%h/v%b/c%0d want=d21/v1/c1", bus.out_data,
                         bus.out_valid, bus.count);
    end
    tick();
  endtask

  task automatic test_hold_flush();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h30 + 8'(i);
      tick();
    end
    bus.out_ready = 1'b1;
    bus.in_data   = 8'h33;
    hold          = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_in_ready got=%b want=0", bus.in_ready);
    end
    tick();
    tick();
    checks++;
    if (bus.count !== 2'd3 || bus.out_data !== 8'h30 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_frozen got=c%0d/d%h/v%b want=c3/d30/v1", bus.count,
                         bus.out_data, bus.out_valid);
    end
    flush = 1'b1;
    tick();
    checks++;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h30) begin
      errors++; $display("FAIL flush_over_hold got=c%0d/v%b/d%h want=c0/v0/d30", bus.count,
                         bus.out_valid, bus.out_data);
    end
    hold         = 1'b0;
    bus.in_data  = 8'h40;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_in_ready got=%b want=1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.count !== 2'd0) begin
      errors++; $display("FAIL flush_discard got=%0d want=0", bus.count);
    end
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h50 + 8'(i);
      tick();
    end
    checks++;
    if (bus.out_data !== 8'h51 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_before got=%h/v%b want=51/v1", bus.out_data, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'hA5 || bus.count !== 2'd0) begin
      errors++; $display("FAIL mid_reset got=v%b/d%h/c%0d want=v0/da5/c0", bus.out_valid,
                         bus.out_data, bus.count);
    end
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h60;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL mid_clean i=%0d got=v%b want=v0", i, bus.out_valid);
      end
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h60 || bus.count !== 2'd1) begin
      errors++; $display("FAIL mid_restart got=v%b/d%h/c%0d want=v1/d60/c1", bus.out_valid,
                         bus.out_data, bus.count);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    flush         = 1'b0;
    hold          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_bubble();
    test_hold_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
